dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 20 ++
 rtl/dmem_arbiter_starve_ctr.sv | 63 ++++++
 rtl/dmem_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states, default sizing
// and the saturating stall-counter increment.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD_CPU = 2'd1,
    ST_RD_DBG = 2'd2
  } arb_state_e;

  localparam int DEF_ADDR_W       = 6;
  localparam int DEF_STARVE_LIMIT = 4;

  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == STALL_CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_starve_ctr.sv
// Grant decision between CPU and debug port, with a starvation counter that
// forces a debug grant after STARVE_LIMIT consecutive CPU wins.
module arb_starve_ctr
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_en,
  input  logic cpu_req,
  input  logic dbg_valid,
  output logic grant_cpu,
  output logic grant_dbg
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             at_limit_s;

  assign at_limit_s = (starve_cnt_q == LIMIT_C);

  // Grant decision: CPU has priority unless debug has waited STARVE_LIMIT grants
  always_comb begin
    grant_cpu = 1'b0;
    grant_dbg = 1'b0;
    if (arb_en) begin
      if (cpu_req && !(dbg_valid && at_limit_s)) begin
        grant_cpu = 1'b1;
      end else if (dbg_valid) begin
        grant_dbg = 1'b1;
      end else begin
        grant_cpu = 1'b0;
      end
    end else begin
      grant_dbg = 1'b0;
    end
  end

  // Starvation count: only meaningful while debug is waiting
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!dbg_valid || grant_dbg) begin
      starve_cnt_d = '0;
    end else if (grant_cpu && !at_limit_s) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-ported data memory shared by the CPU M stage and a debug/loader port.
// Writes complete in the grant cycle; reads return one cycle later.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_valid,
  output logic              dbg_ready,
  input  logic              dbg_we,
  input  logic [31:0]       dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [15:0]       stall_cnt
);

  arb_state_e  state_q, state_d;
  logic [31:0] cpu_hold_q, cpu_hold_d;
  logic [31:0] dbg_hold_q, dbg_hold_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        arb_en_s, grant_cpu_s, grant_dbg_s;
  logic        unused_addr_bits_s;

  assign unused_addr_bits_s = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                                dbg_addr[31:ADDR_W+2], dbg_addr[1:0]};

  // Gating with reset keeps every grant-driven output quiet while reset is held
  assign arb_en_s = reset && (state_q == ST_IDLE);

  arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk      (clk),
    .reset    (reset),
    .arb_en   (arb_en_s),
    .cpu_req  (cpu_req),
    .dbg_valid(dbg_valid),
    .grant_cpu(grant_cpu_s),
    .grant_dbg(grant_dbg_s)
  );

  // Memory port mux driven by the winning requester
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    if (grant_cpu_s) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr[ADDR_W+1:2];
      mem_wdata = cpu_wdata;
    end else if (grant_dbg_s) begin
      mem_en    = 1'b1;
      mem_we    = dbg_we;
      mem_addr  = dbg_addr[ADDR_W+1:2];
      mem_wdata = dbg_wdata;
    end else begin
      mem_en    = 1'b0;
    end
  end

  // Next state, read-data steering and handshake outputs
  always_comb begin
    state_d    = ST_IDLE;
    cpu_hold_d = cpu_hold_q;
    dbg_hold_d = dbg_hold_q;
    cpu_rdata  = cpu_hold_q;
    dbg_rdata  = dbg_hold_q;
    dbg_rvalid = 1'b0;
    dbg_ready  = grant_dbg_s;
    case (state_q)
      ST_IDLE: begin
        if (grant_cpu_s && !cpu_we) begin
          state_d = ST_RD_CPU;
        end else if (grant_dbg_s && !dbg_we) begin
          state_d = ST_RD_DBG;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_CPU: begin
        cpu_rdata  = mem_rdata;
        cpu_hold_d = mem_rdata;
      end
      ST_RD_DBG: begin
        dbg_rvalid = 1'b1;
        dbg_rdata  = mem_rdata;
        dbg_hold_d = mem_rdata;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    cpu_stall   = reset && cpu_req &&
                  !((grant_cpu_s && cpu_we) || (state_q == ST_RD_CPU));
    stall_cnt_d = cpu_stall ? sat_inc16(stall_cnt_q) : stall_cnt_q;
    stall_cnt   = stall_cnt_q;
  end

  // State and holding registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cpu_hold_q  <= 32'd0;
      dbg_hold_q  <= 32'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cpu_hold_q  <= cpu_hold_d;
      dbg_hold_q  <= dbg_hold_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
